alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Iterative multiply/divide unit (RV32M: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) beside the ALU.
//  Produces wide products and quotients over several cycles; a valid/ready handshake on each side
//  lets the pipeline stall while an operation is in flight. The ALU keeps all single-cycle ops.
// PARAMETERS
//  XLEN            32  operand/result width; even, >= 8
//  STEPS_PER_CYCLE  1  radix-2 steps retired per clock; one of 1,2,4; must divide XLEN
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     request present
//  in_ready   out  1     unit can accept a request
//  op         in   3     M-extension funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  a          in   XLEN  rs1 operand
//  b          in   XLEN  rs2 operand
//  flush      in   1     abort in-flight op (branch mispredict/trap)
//  out_valid  out  1     result present
//  out_ready  in   1     consumer takes result
//  result     out  XLEN  selected result word
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, result=0, all datapath regs 0. rst overrides flush.
//  FSM IDLE -> CALC -> DONE -> IDLE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
//  Accept: in_valid&in_ready at edge latches op, a, b; takes abs values for signed operands
//   (MULH: both; MULHSU: a only; DIV/REM: both); records result sign; counter=XLEN/STEPS_PER_CYCLE.
//  Special cases resolved at accept, skip CALC (IDLE->DONE, result valid the following cycle):
//   DIV/DIVU b==0 -> all ones; REM/REMU b==0 -> a;
//   DIV a==-2^(XLEN-1), b==-1 -> a; REM same -> 0.
//  CALC: STEPS_PER_CYCLE radix-2 steps per clock, counter-- per clock.
//   Multiply: shift-add into 2*XLEN accumulator; low XLEN for MUL, high XLEN for MULH*.
//   Divide: restoring shift-subtract; quotient in low reg, partial remainder in high reg.
//   counter reaches 0 -> apply sign (2's-complement negate of 2*XLEN product, or quotient
//   sign a^b, remainder sign of a) -> DONE.
//  Latency accept-edge to out_valid: XLEN/STEPS_PER_CYCLE+1 cycles (33 at defaults); special cases 1.
//  DONE: result held stable while out_valid&!out_ready; out_valid&out_ready -> IDLE, in_ready=1
//   next cycle (no same-cycle accept; throughput one op per latency+1 cycles).
//  flush in any state: -> IDLE next edge, out_valid=0, result discarded; a request presented with
//   flush in IDLE is not accepted.
//  result register updates only on CALC->DONE or special-case accept; no X on result ever.
//  MUL result independent of signedness; MULHU/MULHSU/MULH differ only in top word.
// STRUCTURE
//  Op encodings (MULDIV_OP_*) and FSM state codes go in rv32i-defines.v beside the ALUctl defines.
//  Sub-module muldiv_step: combinational single radix-2 step (mode, acc, divisor/multiplicand ->
//   next acc); top instantiates STEPS_PER_CYCLE copies chained in a generate loop.
//  Top holds FSM, counter, operand/sign registers, handshake logic.
// TESTING
//  MUL a=7,b=-3 -> result 0xFFFFFFEB after 33 cycles; in_ready low throughout.
//  MULH a=0x80000000,b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE;
//   MULHSU a=-1,b=0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV a=-7,b=2 -> -3 (0xFFFFFFFD); REM same -> -1; DIVU a=0xFFFFFFFF,b=0x10 -> 0x0FFFFFFF.
//  DIV b=0 -> 0xFFFFFFFF, REMU a=5,b=0 -> 5, DIV 0x80000000/-1 -> 0x80000000, each at latency 1.
//  out_ready held low 10 cycles in DONE -> result/out_valid stable; then handshake -> in_ready next cycle.
//  flush at cycle 10 of CALC -> IDLE next edge, no out_valid; rst mid-CALC -> reset values next edge;
//   repeat with STEPS_PER_CYCLE=4 (latency 9) and XLEN=16 random vs reference model.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// alu_muldiv_seq_pkg: M-extension op encodings, FSM states and operand classification helpers
package alu_muldiv_seq_pkg;
    localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op inside {MULDIV_OP_DIV, MULDIV_OP_DIVU, MULDIV_OP_REM, MULDIV_OP_REMU};
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op inside {MULDIV_OP_REM, MULDIV_OP_REMU};
    endfunction

    function automatic logic signed_a(input logic [2:0] op);
        return op inside {MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_DIV, MULDIV_OP_REM};
    endfunction

    function automatic logic signed_b(input logic [2:0] op);
        return !(op inside {MULDIV_OP_MUL, MULDIV_OP_MULHSU, MULDIV_OP_MULHU, MULDIV_OP_DIVU, MULDIV_OP_REMU});
    endfunction
endpackage

// File: rtl/alu_muldiv_seq_step.sv
// alu_muldiv_seq_step: one combinational radix-2 step, shift-add multiply or restoring divide
module alu_muldiv_seq_step #(
    parameter int XLEN = 32
) (
    input  logic              div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);
    logic [XLEN:0] sum, rem_sh, diff;

    // Multiply: multiplier sits in the low half and is consumed LSB first.
    // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    always_comb begin
        sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = acc_i[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, opnd_i};
        acc_o  = !div_i    ? {sum, acc_i[XLEN-1:1]}
               : diff[XLEN] ? {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0}
               : {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end
endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative RV32M multiply/divide unit with valid/ready handshakes on both sides
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int N  = XLEN / STEPS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_nx, prod;
    logic [XLEN-1:0]   opnd_q, opnd_d, result_q, result_d;
    logic [XLEN-1:0]   abs_a, abs_b, spec_res, qr, fin;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d, sa, sb, special;

    for (genvar s = 0; s < STEPS_PER_CYCLE; s++) begin : g_step
        logic [2*XLEN-1:0] prev, nxt;
        if (s == 0) begin : g_first
            assign prev = acc_q;
        end else begin : g_rest
            assign prev = g_step[s-1].nxt;
        end
        alu_muldiv_seq_step #(.XLEN(XLEN)) u_step (
            .div_i (is_div(op_q)),
            .acc_i (prev),
            .opnd_i(opnd_q),
            .acc_o (nxt)
        );
    end
    assign acc_nx = g_step[STEPS_PER_CYCLE-1].nxt;

    assign sa    = a[XLEN-1] & signed_a(op);
    assign sb    = b[XLEN-1] & signed_b(op);
    assign abs_a = sa ? -a : a;
    assign abs_b = sb ? -b : b;
    // Divide-by-zero and signed overflow have fixed answers, so they never iterate
    assign special  = is_div(op) && (b == '0 || (signed_b(op) && a == INT_MIN && b == '1));
    assign spec_res = b == '0 ? (is_rem(op) ? a : '1) : (is_rem(op) ? '0 : a);

    assign prod = neg_q ? -acc_nx : acc_nx;
    assign qr   = is_rem(op_q) ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
    assign fin  = is_div(op_q) ? (neg_q ? -qr : qr)
                : op_q == MULDIV_OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE && in_valid) begin
            op_d     = op;
            acc_d    = {{XLEN{1'b0}}, abs_a};
            opnd_d   = abs_b;
            neg_d    = sa ^ (sb & !is_rem(op));
            cnt_d    = CW'(N);
            state_d  = special ? ST_DONE : ST_CALC;
            result_d = special ? spec_res : result_q;
        end else if (state_q == ST_CALC) begin
            acc_d    = acc_nx;
            cnt_d    = cnt_q - CW'(1);
            state_d  = cnt_q == CW'(1) ? ST_DONE : ST_CALC;
            result_d = cnt_q == CW'(1) ? fin : result_q;
        end else if (state_q == ST_DONE && out_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = state_q == ST_IDLE;
    assign out_valid = state_q == ST_DONE;
    assign result    = result_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: scoreboard bench over three configurations (32/1, 32/4, 16/4) with a
// plain-arithmetic reference model for random operations
module tb_alu_muldiv_seq;
    typedef struct packed {
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] e;
        logic        sp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  in_valid_v = '0, flush_v = '0, out_ready_v = '0;
    logic [2:0]  in_ready_v, out_valid_v;
    logic [31:0] res0, res1;
    logic [15:0] res2;
    logic [31:0] q0[$], q1[$], q2[$];
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.XLEN(32), .STEPS_PER_CYCLE(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .op(op),
        .a(a), .b(b), .flush(flush_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .result(res0));
    alu_muldiv_seq #(.XLEN(32), .STEPS_PER_CYCLE(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .op(op),
        .a(a), .b(b), .flush(flush_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .result(res1));
    alu_muldiv_seq #(.XLEN(16), .STEPS_PER_CYCLE(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .op(op),
        .a(a[15:0]), .b(b[15:0]), .flush(flush_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .result(res2));

    function automatic logic [31:0] res_of(input int s);
        return s == 0 ? res0 : s == 1 ? res1 : {16'h0, res2};
    endfunction

    function automatic int width_of(input int s);
        return s == 2 ? 16 : 32;
    endfunction

    function automatic int lat_of(input int s);
        return s == 0 ? 33 : s == 1 ? 9 : 5;
    endfunction

    // RV32M semantics via 64-bit integer arithmetic, truncated to width w
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, y, input int w);
        longint m, ux, uy, sx, sy, r;
        logic [63:0] p;
        m  = (longint'(1) << w) - 1;
        ux = longint'(x) & m;
        uy = longint'(y) & m;
        sx = (ux << (64 - w)) >>> (64 - w);
        sy = (uy << (64 - w)) >>> (64 - w);
        p  = '0;
        r  = 0;
        case (o)
            3'd0: begin p = sx * sy; r = longint'(p) & m; end
            3'd1: begin p = sx * sy; r = longint'(p >> w) & m; end
            3'd2: begin p = sx * uy; r = longint'(p >> w) & m; end
            3'd3: begin p = ux * uy; r = longint'(p >> w) & m; end
            3'd4: r = uy == 0 ? m : (sy == -1 && sx == -(longint'(1) << (w - 1))) ? ux : (sx / sy) & m;
            3'd5: r = uy == 0 ? m : ux / uy;
            3'd6: r = uy == 0 ? ux : (sy == -1) ? 0 : (sx % sy) & m;
            default: r = uy == 0 ? ux : ux % uy;
        endcase
        return 32'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int s, input logic [31:0] e);
        case (s)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic drop_last(input int s);
        case (s)
            0: void'(q0.pop_back());
            1: void'(q1.pop_back());
            default: void'(q2.pop_back());
        endcase
    endtask

    function automatic int qsize(input int s);
        return s == 0 ? q0.size() : s == 1 ? q1.size() : q2.size();
    endfunction

    function automatic logic [31:0] qpop(input int s);
        case (s)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int s = 0; s < 3; s++)
                if (out_valid_v[s] && out_ready_v[s] && !flush_v[s] && !rst) begin
                    if (qsize(s) == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_out dut%0d: result %h with no expected entry", s, res_of(s));
                    end else
                        chk($sformatf("result dut%0d", s), res_of(s), qpop(s));
                end
        end
    endtask

    task automatic start(input int s, input logic [2:0] o, input logic [31:0] x, y, e);
        int t = 0;
        op = o;
        a  = x;
        b  = y;
        in_valid_v[s] = 1'b1;
        while (!in_ready_v[s] && t < 100) begin
            @(posedge clk);
            #1 t++;
        end
        if (t == 100) chk($sformatf("accept_timeout dut%0d", s), 32'(in_ready_v[s]), 1);
        @(posedge clk);
        push(s, e);
        #1 in_valid_v[s] = 1'b0;
    endtask

    task automatic issue(input int s, input logic [2:0] o, input logic [31:0] x, y, e, input logic sp);
        int lat = 1, hi = 0;
        start(s, o, x, y, e);
        while (!out_valid_v[s] && lat < 100) begin
            if (in_ready_v[s]) hi++;
            @(posedge clk);
            #1 lat++;
        end
        chk($sformatf("latency dut%0d op%0d", s, o), lat, sp ? 1 : lat_of(s));
        chk($sformatf("in_ready_busy dut%0d", s), hi, 0);
    endtask

    task automatic drain(input int s);
        out_ready_v[s] = 1'b1;
        @(posedge clk);
        #1;
        chk($sformatf("in_ready_after dut%0d", s), 32'(in_ready_v[s]), 1);
        chk($sformatf("out_valid_after dut%0d", s), 32'(out_valid_v[s]), 0);
    endtask

    vec_t dir [12] = '{
        '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0},
        '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0},
        '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
        '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
        '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0},
        '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0},
        '{3'd5, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 1'b0},
        '{3'd4, 32'd1234,     32'd0,        32'hFFFFFFFF, 1'b1},
        '{3'd5, 32'd1234,     32'd0,        32'hFFFFFFFF, 1'b1},
        '{3'd7, 32'd5,        32'd0,        32'd5,        1'b1},
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1}
    };

    initial begin
        logic [2:0]  o;
        logic [31:0] x, y, m, mn;
        logic        sp;
        int          w, seen;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset in_ready dut%0d", s), 32'(in_ready_v[s]), 1);
            chk($sformatf("reset out_valid dut%0d", s), 32'(out_valid_v[s]), 0);
            chk($sformatf("reset result dut%0d", s), res_of(s), 0);
        end
        rst = 1'b0;
        out_ready_v = '1;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 12; i++) begin
                issue(s, dir[i].o, dir[i].x, dir[i].y, dir[i].e, dir[i].sp);
                drain(s);
            end
        // consumer stall: result and out_valid must hold
        out_ready_v[0] = 1'b0;
        issue(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("hold out_valid", 32'(out_valid_v[0]), 1);
            chk("hold result", res0, 32'hFFFFFFFE);
        end
        drain(0);
        // flush mid-calculation
        start(0, 3'd0, 32'd123, 32'd456, 32'd56088);
        drop_last(0);
        repeat (10) @(posedge clk);
        #1 flush_v[0] = 1'b1;
        @(posedge clk);
        #1 flush_v[0] = 1'b0;
        chk("flush in_ready", 32'(in_ready_v[0]), 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid_v[0]) seen++;
        end
        chk("flush no out_valid", seen, 0);
        // request presented together with flush in IDLE is ignored
        op = 3'd4;
        a = 32'd9;
        b = 32'd0;
        in_valid_v[0] = 1'b1;
        flush_v[0] = 1'b1;
        @(posedge clk);
        #1 in_valid_v[0] = 1'b0;
        flush_v[0] = 1'b0;
        chk("flush_idle in_ready", 32'(in_ready_v[0]), 1);
        chk("flush_idle out_valid", 32'(out_valid_v[0]), 0);
        // reset mid-calculation
        start(0, 3'd4, 32'd100, 32'd7, 32'd14);
        drop_last(0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst in_ready", 32'(in_ready_v[0]), 1);
        chk("rst out_valid", 32'(out_valid_v[0]), 0);
        chk("rst result", res0, 0);
        rst = 1'b0;
        // random operations against the reference model
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 40; k++) begin
                w  = width_of(s);
                m  = w == 32 ? 32'hFFFFFFFF : 32'h0000FFFF;
                mn = 32'(1) << (w - 1);
                o  = 3'($urandom_range(0, 7));
                x  = $urandom & m;
                y  = $urandom & m;
                case ($urandom_range(0, 7))
                    0: y = '0;
                    1: begin x = mn; y = m; end
                    2: y = 32'($urandom_range(1, 15));
                    default: ;
                endcase
                sp = o[2] && (y == '0 || (!o[0] && x == mn && y == m));
                out_ready_v[s] = 1'($urandom_range(0, 1));
                issue(s, o, x, y, model(o, x, y, w), sp);
                if (!out_ready_v[s])
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                drain(s);
            end
        repeat (2) @(posedge clk);
        chk("scoreboard empty", q0.size() + q1.size() + q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
